// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: hazard and multi-cycle sequencing controller for the
// five-stage pipeline. Resolves load-use stalls, taken-branch flushes and the
// mult/div handshake, driving latch write enables and bubble injection.
// State advances on the falling clock edge, together with the pipeline latches.

module pipe_hazard_ctrl #(
    parameter int MD_CNT_W = 6
) (
    input  logic                clk,
    input  logic                clr,
    input  logic [31:0]         fd_ir,
    input  logic [31:0]         dx_ir,
    input  logic                branch_taken,
    input  logic                md_ready,
    output logic                pc_en,
    output logic                fd_en,
    output logic                dx_en,
    output logic                xm_en,
    output logic                mw_en,
    output logic                fd_nop,
    output logic                dx_nop,
    output logic                xm_nop,
    output logic                md_mult,
    output logic                md_div,
    output logic                md_busy,
    output logic [MD_CNT_W-1:0] md_cycles
);

    localparam logic [4:0] OP_ALU  = 5'b00000;
    localparam logic [4:0] OP_LW   = 5'b01000;
    localparam logic [4:0] OP_SW   = 5'b00111;
    localparam logic [4:0] OP_BNE  = 5'b00010;
    localparam logic [4:0] OP_BLT  = 5'b00110;
    localparam logic [4:0] OP_JR   = 5'b00100;
    localparam logic [4:0] ALU_MUL = 5'b00110;
    localparam logic [4:0] ALU_DIV = 5'b00111;

    localparam logic [MD_CNT_W-1:0] CNT_ZERO = {MD_CNT_W{1'b0}};
    localparam logic [MD_CNT_W-1:0] CNT_MAX  = {MD_CNT_W{1'b1}};
    localparam logic [MD_CNT_W-1:0] CNT_ONE  = {{(MD_CNT_W-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_WAIT  = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [MD_CNT_W-1:0] r_md_cycles;
    logic [MD_CNT_W-1:0] w_md_cycles_nxt;

    logic w_dx_mul;
    logic w_dx_div;
    logic w_dx_md;
    logic w_load_use;
    logic w_unused_bits;

    logic w_pc_en;
    logic w_fd_en;
    logic w_dx_en;
    logic w_fd_nop;
    logic w_dx_nop;
    logic w_xm_nop;
    logic w_md_mult;
    logic w_md_div;
    logic w_md_busy;

    // Multiply: ALU opcode with the mul ALU sub-op.
    function automatic logic is_mul(input logic [31:0] ir);
        return (ir[31:27] == OP_ALU) && (ir[6:2] == ALU_MUL);
    endfunction

    // Divide: ALU opcode with the div ALU sub-op.
    function automatic logic is_div(input logic [31:0] ir);
        return (ir[31:27] == OP_ALU) && (ir[6:2] == ALU_DIV);
    endfunction

    // True when the FD instruction reads register r as a source operand.
    // rs is always a source; rt only for R-type; rd for store, compare
    // branches and jr, which use rd as an operand rather than a destination.
    function automatic logic fd_reads_reg(input logic [31:0] ir, input logic [4:0] r);
        logic       hit;
        logic [4:0] op;
        op  = ir[31:27];
        hit = (ir[21:17] == r);
        if (op == OP_ALU) begin
            hit = hit | (ir[16:12] == r);
        end else if ((op == OP_SW) || (op == OP_BNE) || (op == OP_BLT) || (op == OP_JR)) begin
            hit = hit | (ir[26:22] == r);
        end else begin
            hit = hit | 1'b0;
        end
        return hit;
    endfunction

    assign w_dx_mul   = is_mul(dx_ir);
    assign w_dx_div   = is_div(dx_ir);
    assign w_dx_md    = w_dx_mul | w_dx_div;
    // A load into $0 never creates a real dependency.
    assign w_load_use = (dx_ir[31:27] == OP_LW) && (dx_ir[26:22] != 5'd0) &&
                        fd_reads_reg(fd_ir, dx_ir[26:22]);

    // Instruction fields the controller has no use for.
    assign w_unused_bits = ^{fd_ir[11:0], dx_ir[21:7], dx_ir[1:0]};

    // Next-state, counter update and per-cycle pipeline control.
    always_comb begin
        w_state_nxt     = r_state;
        w_md_cycles_nxt = r_md_cycles;
        w_pc_en         = 1'b1;
        w_fd_en         = 1'b1;
        w_dx_en         = 1'b1;
        w_fd_nop        = 1'b0;
        w_dx_nop        = 1'b0;
        w_xm_nop        = 1'b0;
        w_md_mult       = 1'b0;
        w_md_div        = 1'b0;
        w_md_busy       = 1'b0;
        if (clr) begin
            w_state_nxt     = ST_IDLE;
            w_md_cycles_nxt = CNT_ZERO;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_dx_md) begin
                        // Freeze the front end; XM takes a bubble while the op is pending.
                        w_pc_en     = 1'b0;
                        w_fd_en     = 1'b0;
                        w_dx_en     = 1'b0;
                        w_xm_nop    = 1'b1;
                        w_state_nxt = ST_START;
                    end else if (branch_taken) begin
                        // Squash the two wrong-path instructions behind the branch.
                        w_fd_nop = 1'b1;
                        w_dx_nop = 1'b1;
                    end else if (w_load_use) begin
                        // Hold PC/FD one cycle and let the load move on ahead.
                        w_pc_en  = 1'b0;
                        w_fd_en  = 1'b0;
                        w_dx_nop = 1'b1;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end
                ST_START: begin
                    w_pc_en         = 1'b0;
                    w_fd_en         = 1'b0;
                    w_dx_en         = 1'b0;
                    w_xm_nop        = 1'b1;
                    w_md_busy       = 1'b1;
                    w_md_mult       = w_dx_mul;
                    w_md_div        = w_dx_div;
                    w_md_cycles_nxt = CNT_ZERO;
                    w_state_nxt     = ST_WAIT;
                end
                ST_WAIT: begin
                    w_md_busy = 1'b1;
                    if (md_ready) begin
                        // Result is captured into XM this cycle; pipeline resumes.
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_pc_en         = 1'b0;
                        w_fd_en         = 1'b0;
                        w_dx_en         = 1'b0;
                        w_xm_nop        = 1'b1;
                        w_md_cycles_nxt = (r_md_cycles == CNT_MAX) ? r_md_cycles
                                                                   : (r_md_cycles + CNT_ONE);
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                end
            endcase
        end
    end

    // State and wait-cycle counter, updated on the pipeline's falling edge.
    always_ff @(negedge clk) begin
        if (clr) begin
            r_state     <= ST_IDLE;
            r_md_cycles <= CNT_ZERO;
        end else begin
            r_state     <= w_state_nxt;
            r_md_cycles <= w_md_cycles_nxt;
        end
    end

    assign pc_en     = w_pc_en;
    assign fd_en     = w_fd_en;
    assign dx_en     = w_dx_en;
    assign xm_en     = 1'b1;
    assign mw_en     = 1'b1;
    assign fd_nop    = w_fd_nop;
    assign dx_nop    = w_dx_nop;
    assign xm_nop    = w_xm_nop;
    assign md_mult   = w_md_mult;
    assign md_div    = w_md_div;
    assign md_busy   = w_md_busy;
    assign md_cycles = r_md_cycles;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Testbench for pipe_hazard_ctrl: directed vector table, a saturation
// sequence, and randomized traffic against a behavioural reference model.

module tb_pipe_hazard_ctrl;

    localparam int CW     = 6;
    localparam int CW_MAX = (1 << CW) - 1;

    localparam logic [31:0] I_NOP  = 32'h00000000;
    localparam logic [31:0] I_MUL  = 32'h01422018; // mul $5,$1,$2
    localparam logic [31:0] I_DIV  = 32'h0142201C; // div $5,$1,$2
    localparam logic [31:0] I_LW   = 32'h40C20000; // lw  $3,0($1)
    localparam logic [31:0] I_ADD  = 32'h01062000; // add $4,$3,$2
    localparam logic [31:0] I_LW0  = 32'h40020000; // lw  $0,0($1)
    localparam logic [31:0] I_ADD0 = 32'h01002000; // add $4,$0,$2

    // Control bit order: pc fd dx xm mw | fd_nop dx_nop xm_nop | mult div | busy
    localparam logic [10:0] C_RUN     = 11'b11111_000_00_0;
    localparam logic [10:0] C_MDSTALL = 11'b00011_001_00_0;
    localparam logic [10:0] C_STMUL   = 11'b00011_001_10_1;
    localparam logic [10:0] C_STDIV   = 11'b00011_001_01_1;
    localparam logic [10:0] C_WSTALL  = 11'b00011_001_00_1;
    localparam logic [10:0] C_WREADY  = 11'b11111_000_00_1;
    localparam logic [10:0] C_BRANCH  = 11'b11111_110_00_0;
    localparam logic [10:0] C_LOADUSE = 11'b00111_010_00_0;

    typedef struct {
        logic        c;
        logic [31:0] fd;
        logic [31:0] dx;
        logic        bt;
        logic        rdy;
        logic [10:0] ctl;
        int          cyc;
        bit          chk_cyc;
    } vec_t;

    logic          clk = 1'b0;
    logic          clr;
    logic [31:0]   fd_ir;
    logic [31:0]   dx_ir;
    logic          branch_taken;
    logic          md_ready;
    logic          pc_en, fd_en, dx_en, xm_en, mw_en;
    logic          fd_nop, dx_nop, xm_nop;
    logic          md_mult, md_div, md_busy;
    logic [CW-1:0] md_cycles;

    int n_vec = 0;
    int n_bad = 0;

    // Reference model state: m_age = -1 outside a multdiv sequence, else the
    // number of edges since the op was seen in DX; m_count = raw wait count.
    int m_age   = -1;
    int m_count = 0;

    vec_t tbl[26];

    pipe_hazard_ctrl #(.MD_CNT_W(CW)) dut (
        .clk          (clk),
        .clr          (clr),
        .fd_ir        (fd_ir),
        .dx_ir        (dx_ir),
        .branch_taken (branch_taken),
        .md_ready     (md_ready),
        .pc_en        (pc_en),
        .fd_en        (fd_en),
        .dx_en        (dx_en),
        .xm_en        (xm_en),
        .mw_en        (mw_en),
        .fd_nop       (fd_nop),
        .dx_nop       (dx_nop),
        .xm_nop       (xm_nop),
        .md_mult      (md_mult),
        .md_div       (md_div),
        .md_busy      (md_busy),
        .md_cycles    (md_cycles)
    );

    always #5 clk = ~clk;

    wire [10:0] act_ctl = {pc_en, fd_en, dx_en, xm_en, mw_en,
                           fd_nop, dx_nop, xm_nop, md_mult, md_div, md_busy};

    function automatic vec_t mk(input logic c, input logic [31:0] fd, input logic [31:0] dx,
                                input logic bt, input logic rdy, input logic [10:0] ctl,
                                input int cyc, input bit chk_cyc);
        vec_t v;
        v.c = c; v.fd = fd; v.dx = dx; v.bt = bt; v.rdy = rdy;
        v.ctl = ctl; v.cyc = cyc; v.chk_cyc = chk_cyc;
        return v;
    endfunction

    // Drive one cycle of inputs, check at the rising edge, return after the falling edge.
    task automatic apply(input logic c, input logic [31:0] f, input logic [31:0] d,
                         input logic b, input logic r, input logic [10:0] ec,
                         input int ecyc, input bit chk, input string nm);
        clr = c; fd_ir = f; dx_ir = d; branch_taken = b; md_ready = r;
        @(posedge clk);
        n_vec++;
        if ((act_ctl !== ec) || (chk && (md_cycles !== CW'(ecyc)))) begin
            n_bad++;
            $display("FAIL %s: ctl got %b want %b, md_cycles got %0d want %0d",
                     nm, act_ctl, ec, md_cycles, ecyc);
        end
        @(negedge clk);
        #1;
    endtask

    function automatic logic m_is_mul(input logic [31:0] ir);
        return (ir[31:27] == 5'd0) && (ir[6:2] == 5'd6);
    endfunction

    function automatic logic m_is_div(input logic [31:0] ir);
        return (ir[31:27] == 5'd0) && (ir[6:2] == 5'd7);
    endfunction

    // Register-read mask of the FD instruction, tested against the load's rd.
    function automatic logic m_hazard(input logic [31:0] fd, input logic [31:0] dx);
        logic [31:0] mask;
        logic [4:0]  op;
        op   = fd[31:27];
        mask = 32'h1 << fd[21:17];
        if (op == 5'd0) mask = mask | (32'h1 << fd[16:12]);
        if (op inside {5'b00111, 5'b00010, 5'b00110, 5'b00100}) mask = mask | (32'h1 << fd[26:22]);
        return (dx[31:27] == 5'b01000) && (dx[26:22] != 5'd0) && mask[dx[26:22]];
    endfunction

    function automatic logic [10:0] model_ctl(input logic c, input logic [31:0] fd,
                                              input logic [31:0] dx, input logic b, input logic r);
        if (c) return C_RUN;
        if (m_age < 0) begin
            if (m_is_mul(dx) || m_is_div(dx)) return C_MDSTALL;
            if (b) return C_BRANCH;
            if (m_hazard(fd, dx)) return C_LOADUSE;
            return C_RUN;
        end
        if (m_age == 1) begin
            if (m_is_mul(dx)) return C_STMUL;
            if (m_is_div(dx)) return C_STDIV;
            return C_WSTALL;
        end
        return r ? C_WREADY : C_WSTALL;
    endfunction

    task automatic model_step(input logic c, input logic [31:0] dx, input logic r);
        if (c) begin
            m_age = -1; m_count = 0;
        end else if (m_age < 0) begin
            if (m_is_mul(dx) || m_is_div(dx)) m_age = 1;
        end else if (m_age == 1) begin
            m_age = 2; m_count = 0;
        end else if (r) begin
            m_age = -1;
        end else begin
            m_age++; m_count++;
        end
    endtask

    function automatic logic [31:0] rand_ir();
        logic [31:0] ir;
        int          k;
        ir        = $urandom;
        ir[26:22] = 5'($urandom_range(0, 3));
        ir[21:17] = 5'($urandom_range(0, 3));
        ir[16:12] = 5'($urandom_range(0, 3));
        k = $urandom_range(0, 8);
        case (k)
            0:       begin ir[31:27] = 5'b00000; ir[6:2] = 5'b00110; end
            1:       begin ir[31:27] = 5'b00000; ir[6:2] = 5'b00111; end
            2:       ir[31:27] = 5'b01000;
            3:       ir[31:27] = 5'b00000;
            4:       ir[31:27] = 5'b00111;
            5:       ir[31:27] = 5'b00010;
            6:       ir[31:27] = 5'b00100;
            7:       ir[31:27] = 5'b00110;
            default: begin end
        endcase
        return ir;
    endfunction

    initial begin
        logic [31:0] cur_fd;
        logic [31:0] cur_dx;
        logic [10:0] e;
        logic        c, b, r;
        int          ecyc;

        tbl[0]  = mk(1'b1, I_NOP,  I_MUL, 1'b0, 1'b0, C_RUN,     0, 1'b0);
        tbl[1]  = mk(1'b1, I_NOP,  I_MUL, 1'b0, 1'b0, C_RUN,     0, 1'b1);
        tbl[2]  = mk(1'b0, I_NOP,  I_MUL, 1'b0, 1'b0, C_MDSTALL, 0, 1'b1);
        tbl[3]  = mk(1'b0, I_NOP,  I_MUL, 1'b0, 1'b1, C_STMUL,   0, 1'b1);
        tbl[4]  = mk(1'b0, I_NOP,  I_MUL, 1'b0, 1'b0, C_WSTALL,  0, 1'b1);
        tbl[5]  = mk(1'b0, I_NOP,  I_MUL, 1'b0, 1'b0, C_WSTALL,  1, 1'b1);
        tbl[6]  = mk(1'b0, I_NOP,  I_MUL, 1'b0, 1'b0, C_WSTALL,  2, 1'b1);
        tbl[7]  = mk(1'b0, I_NOP,  I_MUL, 1'b0, 1'b1, C_WREADY,  3, 1'b1);
        tbl[8]  = mk(1'b0, I_NOP,  I_NOP, 1'b0, 1'b1, C_RUN,     3, 1'b1);
        tbl[9]  = mk(1'b0, I_ADD,  I_LW,  1'b0, 1'b0, C_LOADUSE, 3, 1'b1);
        tbl[10] = mk(1'b0, I_ADD,  I_NOP, 1'b0, 1'b0, C_RUN,     3, 1'b1);
        tbl[11] = mk(1'b0, I_ADD0, I_LW0, 1'b0, 1'b0, C_RUN,     3, 1'b1);
        tbl[12] = mk(1'b0, I_ADD,  I_LW,  1'b1, 1'b0, C_BRANCH,  3, 1'b1);
        tbl[13] = mk(1'b0, I_DIV,  I_DIV, 1'b0, 1'b0, C_MDSTALL, 3, 1'b1);
        tbl[14] = mk(1'b0, I_DIV,  I_DIV, 1'b0, 1'b0, C_STDIV,   3, 1'b1);
        tbl[15] = mk(1'b0, I_DIV,  I_DIV, 1'b1, 1'b0, C_WSTALL,  0, 1'b1);
        tbl[16] = mk(1'b0, I_DIV,  I_DIV, 1'b0, 1'b1, C_WREADY,  1, 1'b1);
        tbl[17] = mk(1'b0, I_NOP,  I_DIV, 1'b0, 1'b0, C_MDSTALL, 1, 1'b1);
        tbl[18] = mk(1'b0, I_NOP,  I_DIV, 1'b0, 1'b0, C_STDIV,   1, 1'b1);
        tbl[19] = mk(1'b0, I_NOP,  I_DIV, 1'b0, 1'b1, C_WREADY,  0, 1'b1);
        tbl[20] = mk(1'b0, I_NOP,  I_MUL, 1'b0, 1'b0, C_MDSTALL, 0, 1'b1);
        tbl[21] = mk(1'b0, I_NOP,  I_MUL, 1'b0, 1'b0, C_STMUL,   0, 1'b1);
        tbl[22] = mk(1'b0, I_NOP,  I_MUL, 1'b0, 1'b0, C_WSTALL,  0, 1'b1);
        tbl[23] = mk(1'b1, I_NOP,  I_MUL, 1'b0, 1'b0, C_RUN,     1, 1'b1);
        tbl[24] = mk(1'b0, I_NOP,  I_NOP, 1'b0, 1'b1, C_RUN,     0, 1'b1);
        tbl[25] = mk(1'b0, I_NOP,  I_NOP, 1'b0, 1'b0, C_RUN,     0, 1'b1);

        // Directed table: reset, mul, load-use, branch priority, div-div, clr mid-op.
        for (int i = 0; i < 26; i++) begin
            apply(tbl[i].c, tbl[i].fd, tbl[i].dx, tbl[i].bt, tbl[i].rdy,
                  tbl[i].ctl, tbl[i].cyc, tbl[i].chk_cyc, $sformatf("row%0d", i));
        end

        // Long wait: md_cycles must saturate at its maximum.
        apply(1'b1, I_NOP, I_NOP, 1'b0, 1'b0, C_RUN,     0, 1'b1, "sat_clr");
        apply(1'b0, I_NOP, I_MUL, 1'b0, 1'b0, C_MDSTALL, 0, 1'b1, "sat_idle");
        apply(1'b0, I_NOP, I_MUL, 1'b0, 1'b0, C_STMUL,   0, 1'b1, "sat_start");
        for (int w = 0; w < 70; w++) begin
            apply(1'b0, I_NOP, I_MUL, 1'b0, 1'b0, C_WSTALL, (w > CW_MAX) ? CW_MAX : w,
                  1'b1, $sformatf("sat_wait%0d", w));
        end
        apply(1'b0, I_NOP, I_MUL, 1'b0, 1'b1, C_WREADY, CW_MAX, 1'b1, "sat_ready");

        // Randomized traffic with a behavioural latch chain feeding FD/DX.
        m_age   = -1;
        m_count = CW_MAX;
        cur_fd  = I_NOP;
        cur_dx  = I_NOP;
        for (int i = 0; i < 3000; i++) begin
            c = (i == 0) || ($urandom_range(0, 59) == 0);
            b = ($urandom_range(0, 6) == 0);
            r = ($urandom_range(0, 2) == 0);
            e = model_ctl(c, cur_fd, cur_dx, b, r);
            ecyc = (m_count > CW_MAX) ? CW_MAX : m_count;
            apply(c, cur_fd, cur_dx, b, r, e, ecyc, 1'b1, $sformatf("rand%0d", i));
            model_step(c, cur_dx, r);
            if (e[8]) cur_dx = e[4] ? I_NOP : cur_fd;
            if (e[9]) cur_fd = e[5] ? I_NOP : rand_ir();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Hazard and multi-cycle sequencing controller for the five-stage pipeline. It drives the write enables of the PC and the FD/DX/XM/MW latches, and injects nops (bubbles) into the FD, DX and XM latches. Every cycle it resolves three conditions: load-use stalls, taken-branch flushes, and the mult/div handshake. It sits beside the latch chain, decodes the FD and DX instruction registers, and talks to the multdiv unit.

## Interface
Parameters:
- MD_CNT_W, 6, width of the saturating multdiv wait-cycle counter

Ports:
- clk  in  1  pipeline clock; state updates on the falling edge, the same edge the pipeline latches use
- clr  in  1  synchronous active-high reset, sampled on that edge
- fd_ir  in  32  instruction in the FD latch
- dx_ir  in  32  instruction in the DX latch
- branch_taken  in  1  X stage resolved a taken branch or jump this cycle
- md_ready  in  1  multdiv result valid this cycle
- pc_en  out  1  PC write enable
- fd_en  out  1  FD latch write enable
- dx_en  out  1  DX latch write enable
- xm_en  out  1  XM latch write enable
- mw_en  out  1  MW latch write enable
- fd_nop  out  1  replace the FD input with 32'h0
- dx_nop  out  1  replace the DX input with 32'h0
- xm_nop  out  1  replace the XM input IR with 32'h0
- md_mult  out  1  one-cycle ctrl_mult pulse
- md_div  out  1  one-cycle ctrl_div pulse
- md_busy  out  1  multdiv sequence in progress
- md_cycles  out  MD_CNT_W  number of WAIT cycles in the current/last operation, saturating

## Operation
Instruction decode:
- Fields: op=[31:27], rd=[26:22], rs=[21:17], rt=[16:12], aluop=[6:2].
- mul: op=00000 and aluop=00110. div: op=00000 and aluop=00111. lw: op=01000.
- FD source registers:
  - rs, always.
  - rt, if op=00000.
  - rd, if op is one of sw 00111, bne 00010, blt 00110, jr 00100.
- Load-use hazard: dx is lw, dx rd≠0, and dx rd equals any FD source register.

FSM states: IDLE, START, WAIT.
- IDLE, DX holds mul or div:
  - Stall: pc_en=fd_en=dx_en=0, xm_nop=1.
  - Next state START.
- START:
  - Stall as above.
  - md_mult or md_div=1, per the DX instruction.
  - Clear md_cycles. Ignore md_ready.
  - Next state WAIT.
- WAIT:
  - md_busy=1.
  - md_ready=0: stall as above, md_cycles increments (saturates at 2^MD_CNT_W−1).
  - md_ready=1: all enables 1, xm_nop=0 (result captured into XM), next state IDLE.
- IDLE, no md op, priority order:
  1. branch_taken: fd_nop=dx_nop=1, all enables 1.
  2. Load-use: pc_en=fd_en=0, dx_nop=1, dx_en=xm_en=mw_en=1.
  3. Otherwise all enables 1, all nops 0.
- xm_en and mw_en are always 1. Downstream stages drain during stalls.
- md_busy=1 in START and WAIT.
- branch_taken is ignored in START and WAIT, because DX holds a non-branch there.

Boundary behaviour:
- Back-to-back mul/div: on returning to IDLE, a new md op in DX restarts the sequence immediately.
- md_ready high in IDLE with no md op: ignored.
- A load-use dependency on a mul rd does not stall here; bypass covers it.
- clr mid-sequence: state returns to IDLE, md_busy=0, and no further md pulse is issued.

## Timing
- Reset (clr high at an edge): state=IDLE, md_cycles=0.
- While clr is high: all enables 1, all nops 0, md_mult=md_div=0, md_busy=0.
- Enables, nops, md_mult/md_div and md_busy are combinational from state and the current inputs. They are stable before the next falling edge.
- Mult/div stall length: 2+N cycles, where md_ready arrives in the Nth WAIT cycle (N≥1).
- Load-use: exactly one stall cycle.
- Branch flush: two bubbles, entering at the next edge.

## Test plan
- Reset: hold clr for 2 edges with dx_ir=32'h01422018 (mul $5,$1,$2).
  - During clr: all enables=1, md_busy=0, no md_mult.
  - After clr drops: IDLE stall, then md_mult pulses for exactly one cycle.
- Load-use: dx_ir=32'h40C20000 (lw $3,0($1)), fd_ir=32'h01062000 (add $4,$3,$2).
  - Required: pc_en=fd_en=0, dx_nop=1 for one cycle.
  - Repeat with fd reading $0 against lw rd=0: no stall.
- Mul sequence: dx_ir=32'h01422018, md_ready at the 4th WAIT cycle.
  - Stall for 6 cycles. md_mult in cycle 2 only. xm_nop=1 until the ready cycle. md_cycles=3.
  - Next state IDLE.
- Div then div: dx_ir=32'h0142201C on two consecutive operations.
  - Two md_div pulses, each followed by its own WAIT phase, with no cycle in which both md_mult and md_div are asserted.
- Branch vs load-use: branch_taken=1 with the lw/add pair in DX/FD.
  - Required: fd_nop=dx_nop=1, pc_en=1 (flush wins).
- clr asserted during WAIT: next cycle state=IDLE, md_busy=0.
  - md_ready arriving afterwards with a non-md dx_ir causes no effect.
